// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types, slave map and address decode helper for apb_master
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam int NUM_SLV = 5;

    localparam logic [19:0] SLV_BASE [NUM_SLV] = '{
        20'h10000, 20'h10001, 20'h10002, 20'h10003, 20'h10004
    };

    // An all-zero select vector means no slave claims the page.
    localparam logic [NUM_SLV-1:0] SEL_MISS = '0;

    function automatic logic [NUM_SLV-1:0] decode_page(input logic [19:0] page);
        logic [NUM_SLV-1:0] sel;
        sel = SEL_MISS;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (page == SLV_BASE[i]) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - CPU request port and APB bus bundle for apb_master
interface apb_master_if;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        error;

    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL0, PSEL1, PSEL2, PSEL3, PSEL4;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4;
    logic        PREADY0, PREADY1, PREADY2, PREADY3, PREADY4;

    modport master (
        input  transfer, write, addr, wdata,
        output rdata, ready, error,
        output PADDR, PWRITE, PENABLE, PWDATA,
        output PSEL0, PSEL1, PSEL2, PSEL3, PSEL4,
        input  PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4,
        input  PREADY0, PREADY1, PREADY2, PREADY3, PREADY4
    );

    modport slave (
        output transfer, write, addr, wdata,
        input  rdata, ready, error,
        input  PADDR, PWRITE, PENABLE, PWDATA,
        input  PSEL0, PSEL1, PSEL2, PSEL3, PSEL4,
        output PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4,
        output PREADY0, PREADY1, PREADY2, PREADY3, PREADY4
    );
endinterface

// File: rtl/apb_master_decoder.sv
// rtl/apb_master_decoder.sv - page decode to one-hot select and PREADY/PRDATA return mux
module apb_master_decoder
    import apb_master_pkg::*;
(
    input  logic [19:0]        page,
    output logic [NUM_SLV-1:0] sel,
    output logic               miss,
    input  logic [NUM_SLV-1:0] sel_q,
    input  logic [NUM_SLV-1:0] pready_in,
    input  logic [31:0]        prdata_in [NUM_SLV],
    output logic               pready,
    output logic [31:0]        prdata
);

    // The return mux is keyed by the latched select, so slaves that are not
    // part of the current transfer can never complete it.
    always_comb begin
        sel    = decode_page(page);
        miss   = (sel == SEL_MISS);
        pready = |(sel_q & pready_in);
        prdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            prdata = prdata | ({32{sel_q[i]}} & prdata_in[i]);
        end
    end

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB initiator: latches a CPU request and runs SETUP/ACCESS with timeout
module apb_master
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic PCLK,
    input  logic PRESET,
    apb_master_if.master bus
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t             state;
    logic [NUM_SLV-1:0] psel;
    logic               penable;
    logic               pwrite;
    logic [31:0]        paddr;
    logic [31:0]        pwdata;
    logic [31:0]        rdata;
    logic               ready;
    logic               error;
    logic [15:0]        wait_cnt;

    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_miss;
    logic               sel_ready;
    logic [31:0]        sel_prdata;
    logic [NUM_SLV-1:0] pready_in;
    logic [31:0]        prdata_in [NUM_SLV];

    assign pready_in    = {bus.PREADY4, bus.PREADY3, bus.PREADY2, bus.PREADY1, bus.PREADY0};
    assign prdata_in[0] = bus.PRDATA0;
    assign prdata_in[1] = bus.PRDATA1;
    assign prdata_in[2] = bus.PRDATA2;
    assign prdata_in[3] = bus.PRDATA3;
    assign prdata_in[4] = bus.PRDATA4;

    apb_master_decoder u_decoder (
        .page      (bus.addr[31:12]),
        .sel       (dec_sel),
        .miss      (dec_miss),
        .sel_q     (psel),
        .pready_in (pready_in),
        .prdata_in (prdata_in),
        .pready    (sel_ready),
        .prdata    (sel_prdata)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            psel     <= SEL_MISS;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            rdata    <= '0;
            ready    <= 1'b0;
            error    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.transfer) begin
                        if (dec_miss) begin
                            ready <= 1'b1;
                            error <= 1'b1;
                            rdata <= '0;
                        end else begin
                            paddr    <= bus.addr;
                            pwrite   <= bus.write;
                            pwdata   <= bus.wdata;
                            psel     <= dec_sel;
                            wait_cnt <= '0;
                            state    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        psel    <= SEL_MISS;
                        penable <= 1'b0;
                        ready   <= 1'b1;
                        if (!pwrite) begin
                            rdata <= sel_prdata;
                        end
                        state   <= IDLE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        // This cycle is the TIMEOUT_CYCLES-th ACCESS cycle without PREADY.
                        psel    <= SEL_MISS;
                        penable <= 1'b0;
                        ready   <= 1'b1;
                        error   <= 1'b1;
                        rdata   <= '0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    psel    <= SEL_MISS;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.PSEL0   = psel[0];
    assign bus.PSEL1   = psel[1];
    assign bus.PSEL2   = psel[2];
    assign bus.PSEL3   = psel[3];
    assign bus.PSEL4   = psel[4];
    assign bus.PENABLE = penable;
    assign bus.PWRITE  = pwrite;
    assign bus.PADDR   = paddr;
    assign bus.PWDATA  = pwdata;
    assign bus.rdata   = rdata;
    assign bus.ready   = ready;
    assign bus.error   = error;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master with five behavioural APB slaves
module tb_apb_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_if bus();

    apb_master #(.TIMEOUT_CYCLES(16)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Slave 0: zero wait, always ready (even when not selected).
    // Slave 1: three extra wait states, constant data.  Slave 2: never ready.
    // Slave 3: RAM with registered PREADY.  Slave 4: registered PREADY, data from address.
    logic [31:0] mem [1024];
    logic [2:0]  s1_cnt;
    logic        s3_rdy, s4_rdy;
    logic [4:0]  psel_v;

    assign psel_v      = {bus.PSEL4, bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};
    assign bus.PREADY0 = 1'b1;
    assign bus.PRDATA0 = bus.PADDR ^ 32'h5A5A_0000;
    assign bus.PREADY1 = bus.PSEL1 & bus.PENABLE & (s1_cnt == 3'd3);
    assign bus.PRDATA1 = 32'h0000_00A5;
    assign bus.PREADY2 = 1'b0;
    assign bus.PRDATA2 = 32'hFFFF_FFFF;
    assign bus.PREADY3 = s3_rdy;
    assign bus.PRDATA3 = mem[bus.PADDR[11:2]];
    assign bus.PREADY4 = s4_rdy;
    assign bus.PRDATA4 = bus.PADDR + 32'd1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_cnt <= 3'd0;
            s3_rdy <= 1'b0;
            s4_rdy <= 1'b0;
        end else begin
            s1_cnt <= (bus.PSEL1 && bus.PENABLE && !bus.PREADY1) ? s1_cnt + 3'd1 : 3'd0;
            s3_rdy <= bus.PSEL3 && bus.PENABLE && !s3_rdy;
            s4_rdy <= bus.PSEL4 && bus.PENABLE && !s4_rdy;
            if (bus.PSEL3 && bus.PENABLE && s3_rdy && bus.PWRITE)
                mem[bus.PADDR[11:2]] <= bus.PWDATA;
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    end

    // Reference model state
    logic [31:0] ref_mem [int];
    logic [31:0] last_rdata = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // idx 0..4 targets a slave, idx 5 is a decode miss on page mpage.
    task automatic do_xfer(input int idx, input logic wr, input logic [11:0] off,
                           input logic [31:0] wd, input logic [19:0] mpage);
        logic [31:0] a, exp_rd;
        logic [4:0]  exp_mask;
        int lat, pen_exp, pen_n, sel_bad, hold_bad, got;
        logic err;
        a        = (idx < 5) ? {20'h10000 + 20'(idx), off} : {mpage, off};
        exp_mask = (idx < 5) ? 5'(1 << idx) : 5'd0;
        err      = 1'b0;
        case (idx)
            0:       begin lat = 3;  pen_exp = 1;  exp_rd = a ^ 32'h5A5A_0000; end
            1:       begin lat = 6;  pen_exp = 4;  exp_rd = 32'h0000_00A5; end
            2:       begin lat = 18; pen_exp = 16; exp_rd = 32'd0; err = 1'b1; end
            3:       begin lat = 4;  pen_exp = 2;
                           exp_rd = ref_mem.exists(int'(a[11:2])) ? ref_mem[int'(a[11:2])] : 32'd0; end
            4:       begin lat = 4;  pen_exp = 2;  exp_rd = a + 32'd1; end
            default: begin lat = 1;  pen_exp = 0;  exp_rd = 32'd0; err = 1'b1; end
        endcase
        if (!err && wr) exp_rd = last_rdata;

        bus.transfer = 1'b1; bus.write = wr; bus.addr = a; bus.wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.transfer = 1'b0;
        pen_n = 0; sel_bad = 0; hold_bad = 0; got = 0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.ready) begin got = n; break; end
            if ($countones(psel_v) > 1 || (psel_v & ~exp_mask) != 5'd0) sel_bad++;
            if (n == 1 && idx < 5 && (psel_v !== exp_mask || bus.PENABLE !== 1'b0)) sel_bad++;
            if (bus.PENABLE && psel_v == 5'd0) sel_bad++;
            if (psel_v != 5'd0 && (bus.PADDR !== a || bus.PWRITE !== wr || (wr && bus.PWDATA !== wd)))
                hold_bad++;
            if (bus.PENABLE) pen_n++;
            // Requests arriving outside IDLE must be ignored.
            bus.transfer = 1'($urandom_range(0, 1));
            bus.write = 1'($urandom_range(0, 1));
            bus.addr = {20'h10000 + 20'($urandom_range(0, 4)), 12'($urandom)};
            bus.wdata = $urandom;
            @(negedge clk);
        end
        bus.transfer = 1'b0;
        check($sformatf("latency[%0d]", idx), got, lat);
        check($sformatf("error[%0d]", idx), {31'd0, bus.error}, {31'd0, err});
        if (got != 0) check($sformatf("rdata[%0d]", idx), bus.rdata, exp_rd);
        check($sformatf("penable_cycles[%0d]", idx), pen_n, pen_exp);
        check($sformatf("select_rules[%0d]", idx), sel_bad, 0);
        check($sformatf("hold_stable[%0d]", idx), hold_bad, 0);
        check($sformatf("idle_at_ready[%0d]", idx), {26'd0, psel_v, bus.PENABLE}, 32'd0);

        if (err) last_rdata = 32'd0;
        else if (!wr) last_rdata = exp_rd;
        else if (idx == 3) ref_mem[int'(a[11:2])] = wd;
    endtask

    task automatic idle_check(input int cycles);
        int seen;
        seen = 0;
        bus.transfer = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.ready || psel_v != 5'd0 || bus.PENABLE) seen++;
        end
        check("idle_quiet", seen, 0);
    endtask

    initial begin
        int idx;
        bus.transfer = 1'b0; bus.write = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {24'd0, psel_v, bus.PENABLE, bus.ready, bus.error}, 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        check("reset_paddr", bus.PADDR | bus.PWDATA | {31'd0, bus.PWRITE}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_xfer(3, 1'b1, 12'h004, 32'hDEAD_BEEF, 20'h0);
        check("ram_word1", mem[1], 32'hDEAD_BEEF);
        do_xfer(3, 1'b0, 12'h004, 32'h0, 20'h0);
        do_xfer(1, 1'b0, 12'h000, 32'h0, 20'h0);
        do_xfer(5, 1'b0, 12'h000, 32'h0, 20'h20000);
        do_xfer(0, 1'b0, 12'h010, 32'h0, 20'h0);
        do_xfer(2, 1'b1, 12'h020, 32'h1111_2222, 20'h0);
        do_xfer(3, 1'b0, 12'h004, 32'h0, 20'h0);
        idle_check(3);
        check("paddr_held", bus.PADDR, 32'h1000_3004);

        // Reset in the middle of an ACCESS to the never-ready slave.
        bus.transfer = 1'b1; bus.write = 1'b0; bus.addr = 32'h1000_2000; bus.wdata = 32'd0;
        @(posedge clk);
        @(negedge clk);
        bus.transfer = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_access", {30'd0, bus.PSEL2, bus.PENABLE}, 32'd3);
        #2 rst = 1'b1;
        #1 check("async_reset_drop", {26'd0, psel_v, bus.PENABLE}, 32'd0);
        @(negedge clk);
        check("reset_no_ready", {31'd0, bus.ready}, 32'd0);
        rst = 1'b0;
        last_rdata = 32'd0;
        do_xfer(3, 1'b1, 12'h008, 32'h1234_5678, 20'h0);
        do_xfer(3, 1'b0, 12'h008, 32'h0, 20'h0);

        for (int k = 0; k < 40; k++) begin
            idx = $urandom_range(0, 5);
            do_xfer(idx, 1'($urandom_range(0, 1)), {10'($urandom_range(0, 15)), 2'b00},
                    $urandom, 20'h20000 + 20'($urandom_range(0, 255)));
        end
        idle_check(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
